// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Assembles a byte stream
//               (4-byte LE word count, N LE payload words, 1 checksum byte)
//               into 32-bit words, writes them to instruction memory at
//               word-aligned byte addresses and holds the core until a
//               checksum-verified image is present.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_hold,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0]      c_depth = 32'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_byte_cnt;
    logic [23:0]      r_shift;      // first three bytes of the word in flight
    logic [CNT_W-1:0] r_count;      // image length N from the header
    logic [CNT_W-1:0] r_word_idx;
    logic [7:0]       r_sum;
    logic             r_imem_we;
    logic [31:0]      r_imem_addr;
    logic [31:0]      r_imem_wdata;
    logic [CNT_W-1:0] r_words_loaded;

    logic             w_accept;
    logic             w_last_byte;
    logic [31:0]      w_word_full;
    logic [CNT_W-1:0] w_idx_next;
    logic [7:0]       w_sum_next;

    assign in_ready     = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign core_hold    = (r_state != S_DONE);
    assign load_done    = (r_state == S_DONE);
    assign load_err     = (r_state == S_ERR);
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign words_loaded = r_words_loaded;

    assign w_accept     = in_valid && in_ready;
    assign w_last_byte  = (r_byte_cnt == 2'd3);
    // Newest byte lands in [31:24], so the first byte ends up in [7:0].
    assign w_word_full  = {in_data, r_shift};
    assign w_idx_next   = r_word_idx + c_one;
    assign w_sum_next   = r_sum + in_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: header length check, word count, checksum verdict.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_accept && w_last_byte) begin
                    if (w_word_full > c_depth) begin
                        w_state_next = S_ERR;
                    end else if (w_word_full == 32'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && (w_idx_next == r_count)) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_next = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    w_state_next = S_HDR;
                end
            end
            default: w_state_next = S_HDR;
        endcase
    end

    // Byte assembly, payload sum, registered memory write and word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt     <= 2'd0;
            r_shift        <= 24'd0;
            r_count        <= '0;
            r_word_idx     <= '0;
            r_sum          <= 8'd0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= 32'd0;
            r_imem_wdata   <= 32'd0;
            r_words_loaded <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {in_data, r_shift[23:8]};
                        if (w_last_byte) begin
                            r_count <= w_word_full[CNT_W-1:0];
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {in_data, r_shift[23:8]};
                        r_sum      <= w_sum_next;
                        if (w_last_byte) begin
                            r_imem_we      <= 1'b1;
                            r_imem_addr    <= {{(30-CNT_W){1'b0}}, r_word_idx, 2'b00};
                            r_imem_wdata   <= w_word_full;
                            r_word_idx     <= w_idx_next;
                            r_words_loaded <= w_idx_next;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_byte_cnt     <= 2'd0;
                        r_word_idx     <= '0;
                        r_sum          <= 8'd0;
                        r_words_loaded <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             core_hold;
    logic             load_done;
    logic             load_err;
    logic [CNT_W-1:0] words_loaded;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] wr_q[$];   // {addr, data} of every write strobe seen

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int tries;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        tries = 0;
        while (in_ready !== 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Nominal 2-word image; the last byte is the checksum.
    task automatic send_nominal(input logic [7:0] csum, input bit gaps);
        logic [7:0] s [13];
        s = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};
        s[12] = csum;
        for (int i = 0; i < 13; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            send_byte(s[i]);
        end
    endtask

    task automatic check_nominal_writes(input string tag);
        logic [63:0] e0, e1, a0, a1;
        e0 = {32'h0000_0000, 32'h0000_0013};
        e1 = {32'h0000_0004, 32'h0010_0093};
        a0 = (wr_q.size() > 0) ? wr_q[0] : 64'hx;
        a1 = (wr_q.size() > 1) ? wr_q[1] : 64'hx;
        check({tag, "_nwr"},   wr_q.size(), 32'd2);
        check({tag, "_addr0"}, a0[63:32], e0[63:32]);
        check({tag, "_data0"}, a0[31:0],  e0[31:0]);
        check({tag, "_addr1"}, a1[63:32], e1[63:32]);
        check({tag, "_data1"}, a1[31:0],  e1[31:0]);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        start    = 1'b0;

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",    {31'd0, imem_we},    32'd0);
        check("rst_addr",  imem_addr,           32'd0);
        check("rst_wdata", imem_wdata,          32'd0);
        check("rst_hold",  {31'd0, core_hold},  32'd1);
        check("rst_done",  {31'd0, load_done},  32'd0);
        check("rst_err",   {31'd0, load_err},   32'd0);
        check("rst_words", 32'(words_loaded),   32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'd0, in_ready},   32'd1);

        // ---- Nominal load with write-latency checks ----
        wr_q.delete();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("hdr_no_we", {31'd0, imem_we}, 32'd0);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        check("pre_we", {31'd0, imem_we}, 32'd0);
        send_byte(8'h00);
        check("w0_we",    {31'd0, imem_we},  32'd1);
        check("w0_words", 32'(words_loaded), 32'd1);
        check("w0_addr",  imem_addr,         32'h0);
        check("w0_data",  imem_wdata,        32'h0000_0013);
        send_byte(8'h93);
        check("w0_pulse1", {31'd0, imem_we}, 32'd0);
        check("w0_hold_addr", imem_addr,     32'h0);
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check("w1_we", {31'd0, imem_we}, 32'd1);
        check("w1_in_ready", {31'd0, in_ready}, 32'd1);
        check("pre_csum_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h4A);
        check("nom_done",  {31'd0, load_done}, 32'd1);
        check("nom_hold",  {31'd0, core_hold}, 32'd0);
        check("nom_err",   {31'd0, load_err},  32'd0);
        check("nom_words", 32'(words_loaded),  32'd2);
        check("nom_ready", {31'd0, in_ready},  32'd0);
        check_nominal_writes("nom");
        // Bytes offered in DONE are not consumed.
        @(negedge clk); in_data = 8'h55; in_valid = 1'b1;
        idle(3); in_valid = 1'b0;
        check("done_ignore", {31'd0, load_done}, 32'd1);
        check("done_words",  32'(words_loaded),  32'd2);

        // ---- Bad checksum ----
        pulse_start();
        check("start_hold",  {31'd0, core_hold}, 32'd1);
        check("start_done",  {31'd0, load_done}, 32'd0);
        check("start_ready", {31'd0, in_ready},  32'd1);
        check("start_words", 32'(words_loaded),  32'd0);
        wr_q.delete();
        send_nominal(8'h4B, 1'b0);
        check("bad_err",   {31'd0, load_err},  32'd1);
        check("bad_done",  {31'd0, load_done}, 32'd0);
        check("bad_hold",  {31'd0, core_hold}, 32'd1);
        check("bad_ready", {31'd0, in_ready},  32'd0);
        idle(1);
        check_nominal_writes("bad");

        // ---- Oversize header ----
        pulse_start();
        check("restart_err_clr", {31'd0, load_err}, 32'd0);
        wr_q.delete();
        send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
        check("ovr_pre_err", {31'd0, load_err}, 32'd0);
        send_byte(8'h00);
        check("ovr_err",   {31'd0, load_err}, 32'd1);
        check("ovr_ready", {31'd0, in_ready}, 32'd0);
        idle(3);
        check("ovr_nwr", wr_q.size(), 32'd0);

        // ---- Empty image, then nominal reload ----
        pulse_start();
        wr_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        check("empty_done",  {31'd0, load_done}, 32'd1);
        check("empty_words", 32'(words_loaded),  32'd0);
        idle(2);
        check("empty_nwr",   wr_q.size(),        32'd0);
        pulse_start();
        wr_q.delete();
        send_nominal(8'h4A, 1'b0);
        check("reload_done", {31'd0, load_done}, 32'd1);
        idle(1);
        check_nominal_writes("reload");

        // ---- Random in_valid gaps ----
        pulse_start();
        wr_q.delete();
        send_nominal(8'h4A, 1'b1);
        check("gap_done",  {31'd0, load_done}, 32'd1);
        check("gap_words", 32'(words_loaded),  32'd2);
        idle(1);
        check_nominal_writes("gap");

        // ---- Asynchronous reset mid-load ----
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we",    {31'd0, imem_we},   32'd0);
        check("arst_addr",  imem_addr,          32'd0);
        check("arst_wdata", imem_wdata,         32'd0);
        check("arst_hold",  {31'd0, core_hold}, 32'd1);
        check("arst_done",  {31'd0, load_done}, 32'd0);
        check("arst_err",   {31'd0, load_err},  32'd0);
        check("arst_words", 32'(words_loaded),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        wr_q.delete();
        send_nominal(8'h4A, 1'b0);
        check("arst_reload_done", {31'd0, load_done}, 32'd1);
        idle(1);
        check_nominal_writes("arst");

        // ---- start pulse during DATA has no effect ----
        pulse_start();
        wr_q.delete();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        pulse_start();
        check("sdata_hold", {31'd0, core_hold}, 32'd1);
        send_byte(8'h00); send_byte(8'h00);
        check("sdata_words1", 32'(words_loaded), 32'd1);
        pulse_start();
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h4A);
        check("sdata_done",  {31'd0, load_done}, 32'd1);
        check("sdata_words", 32'(words_loaded),  32'd2);
        idle(1);
        check_nominal_writes("sdata");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
